freq_trim_seq: RTL and testbench
================================

// Module: freq_trim_seq
// PURPOSE
//  Run-control sequencer that sits directly upstream of the freq_trim engine, in the rclk domain.
//  Drives the engine's setb/ena/msb and the oscillator select, and walks every enabled oscillator
//  channel through two passes: a measure pass (ena=0), then a successive-approximation trim pass (ena=1).
//  Captures the measured count and the final trim code per channel, and reports timeout errors.
// PARAMETERS
//  NCH   6       number of oscillator channels, 1..8
//  GAP   16      rclk cycles of settle time before every setb/ena transition, >=4
//  TMO   65535   rclk cycles allowed while waiting on ft_done, before the channel is flagged
// PORTS
//  rstb       in   1        async active-low reset
//  rclk       in   1        reference clock; the only clock of this block
//  start      in   1        single-cycle pulse; starts a sequence over the channels in chan_mask
//  abort      in   1        single-cycle pulse; stops the sequence in progress
//  chan_mask  in   NCH      channel enables, sampled on start
//  msb_tab    in   4*NCH    msb per channel; channel k uses [4k+3:4k]
//  chan_sel   out  3        channel currently routed to the engine (oclk/odiv mux select)
//  ft_setb    out  1        to freq_trim setb
//  ft_ena     out  1        to freq_trim ena
//  ft_msb     out  4        to freq_trim msb; equals msb_tab[chan_sel]
//  ft_done    in   1        from freq_trim done; oclk domain, asynchronous to rclk
//  ft_trim    in   16       from freq_trim trim; sampled only when quasi-static
//  ft_ocnt    in   16       from freq_trim ocnt; sampled only when quasi-static
//  busy       out  1        high from the cycle after start up to and including FIN
//  seq_done   out  1        one-cycle pulse when the sequence ends (normal end or abort)
//  err        out  NCH      sticky per-channel timeout flag; cleared on start
//  trim_out   out  16*NCH   final trim code per channel
//  meas_out   out  16*NCH   measure-pass count per channel (oclk cycles per rdiv rclk cycles)
// BEHAVIOUR
//  Reset values: all outputs 0; FSM in IDLE; ft_setb=0, ft_ena=0, chan_sel=0.
//  ft_done passes through a 2-flop synchroniser to give done_s (2-3 rclk latency). done_r is the
//   rising edge of done_s.
//  FSM states: IDLE, NEXT, M_ARM, M_RUN, M_CAP, T_ARM, T_RUN, T_CAP, ADV, FIN.
//   - IDLE: on start, latch chan_mask into mask_q, clear err, set busy, go to NEXT.
//     start is ignored unless the FSM is in IDLE.
//   - NEXT: chan_sel = lowest set bit of mask_q, go to M_ARM. If mask_q==0, go to FIN.
//   - M_ARM: setb=0, ena=0. Wait for GAP cycles elapsed AND done_s==0, then go to M_RUN.
//   - M_RUN: setb=1. On done_r go to M_CAP. After TMO cycles, set err[chan_sel] and go to ADV.
//   - M_CAP: capture meas_out[chan_sel] = ft_ocnt, drop setb=0, go to T_ARM.
//     ocnt is frozen once done is high, so this sample is safe.
//   - T_ARM: setb=0, then ena=1 once GAP cycles have elapsed. After a further GAP cycles
//     with done_s==0, go to T_RUN.
//   - T_RUN: setb=1. On done_r go to T_CAP. On TMO expiry, set err[chan_sel] and go to ADV.
//   - T_CAP: capture trim_out[chan_sel] = ft_trim, go to ADV.
//   - ADV: setb=0, ena=0, clear mask_q[chan_sel]. Wait GAP cycles, then go to NEXT.
//   - FIN: pulse seq_done for 1 cycle, drop busy, go to IDLE.
//  GAP and TMO share one cycle counter. The counter is reloaded on every state change and
//   saturates at 0; it never wraps.
//  A timed-out channel keeps its previous trim_out/meas_out values.
//  abort in any state except IDLE: force setb=0, ena=0, go to ADV-like drain (GAP cycles),
//   then FIN. err, trim_out and meas_out are retained.
//  abort has priority over a done_r in the same cycle.
//  start together with abort while in IDLE: start wins; abort is ignored.
//  Reset mid-sequence: immediate return to the reset state. Captured results are lost.
//  ft_msb is combinational from msb_tab and the registered chan_sel; chan_sel changes only in
//   NEXT, while setb=0.
// STRUCTURE
//  Package freq_trim_pkg: FSM state enum, NCH_MAX=8, cycle-counter width = $clog2(TMO+1).
//  Sub-module sync2 (rstb, clk, d, q): 2-flop synchroniser used for ft_done; reusable.
//  The rest is flat: FSM, counter, mask_q, priority encoder, result register arrays.
// TESTING (bench: freq_trim_seq + freq_trim + behavioural oscillators)
//  1. chan_mask=6'b000001, msb_tab[3:0]=7, osc ideal at odiv=rdiv*8/24
//     -> meas_out[0] within 1 of odiv, trim_out[0] converged, err=0, one seq_done pulse.
//  2. chan_mask=6'b101010, msb 7/11/11 -> channels visited in order 1,3,5.
//     chan_sel never changes while ft_setb=1; unmasked channels' results stay 0.
//  3. Channel 2 oscillator held stopped, TMO=1000 -> err=6'b000100 after 1000 cycles in M_RUN;
//     the sequence continues and finishes with seq_done.
//  4. abort 50 cycles into T_RUN of channel 0 with mask 6'b000011
//     -> ft_setb=0 next cycle, busy falls after GAP+1 cycles, channel 1 never selected.
//  5. chan_mask=0 and start -> seq_done 2 cycles later, ft_setb never asserted.
//     A start while busy has no effect.
//  6. rstb pulsed low during M_RUN -> all outputs 0 the same cycle.
//     A new start after rstb release runs a full sequence.

Source files
------------

// File: rtl/freq_trim_pkg.sv
// rtl/freq_trim_pkg.sv - shared types and constants for the freq_trim run-control sequencer
package freq_trim_pkg;

    localparam int NCH_MAX = 8;
    localparam int TMO_MAX = 65535;
    localparam int CNT_W   = $clog2(TMO_MAX + 1);

    typedef enum logic [3:0] {
        IDLE,
        NEXT,
        M_ARM,
        M_RUN,
        M_CAP,
        T_ARM,
        T_RUN,
        T_CAP,
        ADV,
        FIN
    } state_t;

    function automatic logic [2:0] lowest_set(input logic [NCH_MAX-1:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int i = NCH_MAX - 1; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/freq_trim_seq_sync2.sv
// rtl/freq_trim_seq_sync2.sv - two-flop synchroniser for a single asynchronous level
module sync2 (
    input  logic rstb,
    input  logic clk,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/freq_trim_seq.sv
// rtl/freq_trim_seq.sv - walks enabled oscillator channels through measure and trim passes
module freq_trim_seq
    import freq_trim_pkg::*;
#(
    parameter int NCH = 6,
    parameter int GAP = 16,
    parameter int TMO = 65535
) (
    input  logic              rstb,
    input  logic              rclk,
    input  logic              start,
    input  logic              abort,
    input  logic [NCH-1:0]    chan_mask,
    input  logic [4*NCH-1:0]  msb_tab,
    output logic [2:0]        chan_sel,
    output logic              ft_setb,
    output logic              ft_ena,
    output logic [3:0]        ft_msb,
    input  logic              ft_done,
    input  logic [15:0]       ft_trim,
    input  logic [15:0]       ft_ocnt,
    output logic              busy,
    output logic              seq_done,
    output logic [NCH-1:0]    err,
    output logic [16*NCH-1:0] trim_out,
    output logic [16*NCH-1:0] meas_out
);

    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] TMO_LD = CNT_W'(TMO - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NCH-1:0]      mask_q, mask_d;
    logic [NCH-1:0]      err_q, err_d;
    logic [2:0]          sel_q, sel_d;
    logic                setb_q, setb_d;
    logic                ena_q, ena_d;
    logic                busy_q, busy_d;
    logic                sdone_q, sdone_d;
    logic                phase_q, phase_d;
    logic                abrt_q, abrt_d;
    logic                done_p_q;
    logic [16*NCH-1:0]   trim_q, trim_d;
    logic [16*NCH-1:0]   meas_q, meas_d;
    logic                done_s;
    logic                done_r;
    logic                cnt_zero;
    logic [NCH_MAX-1:0]  mask_ext;

    sync2 u_done_sync (
        .rstb (rstb),
        .clk  (rclk),
        .d    (ft_done),
        .q    (done_s)
    );

    assign done_r   = done_s & ~done_p_q;
    assign cnt_zero = (cnt_q == '0);
    assign mask_ext = NCH_MAX'(mask_q);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        err_d   = err_q;
        sel_d   = sel_q;
        phase_d = phase_q;
        abrt_d  = abrt_q;
        busy_d  = busy_q;
        trim_d  = trim_q;
        meas_d  = meas_q;
        cnt_d   = cnt_zero ? '0 : cnt_q - CNT_W'(1);

        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d  = chan_mask;
                    err_d   = '0;
                    abrt_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (mask_q == '0) begin
                    state_d = FIN;
                end else begin
                    sel_d   = lowest_set(mask_ext);
                    state_d = M_ARM;
                end
            end
            M_ARM: if (cnt_zero && !done_s) state_d = M_RUN;
            M_RUN: begin
                if (done_r) begin
                    state_d = M_CAP;
                end else if (cnt_zero) begin
                    err_d[sel_q] = 1'b1;
                    state_d      = ADV;
                end
            end
            M_CAP: begin
                meas_d[16*sel_q +: 16] = ft_ocnt;
                state_d                = T_ARM;
            end
            // Two settle windows: setb low first, then ena high before the trim run.
            T_ARM: begin
                if (cnt_zero) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        cnt_d   = GAP_LD;
                    end else if (!done_s) begin
                        state_d = T_RUN;
                    end
                end
            end
            T_RUN: begin
                if (done_r) begin
                    state_d = T_CAP;
                end else if (cnt_zero) begin
                    err_d[sel_q] = 1'b1;
                    state_d      = ADV;
                end
            end
            T_CAP: begin
                trim_d[16*sel_q +: 16] = ft_trim;
                state_d                = ADV;
            end
            ADV: begin
                mask_d[sel_q] = 1'b0;
                if (cnt_zero) state_d = abrt_q ? FIN : NEXT;
            end
            FIN: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            phase_d = 1'b0;
            case (state_d)
                M_ARM, T_ARM, ADV: cnt_d = GAP_LD;
                M_RUN, T_RUN:      cnt_d = TMO_LD;
                default:           cnt_d = '0;
            endcase
        end

        // Abort overrides any transition, including a done edge seen this cycle.
        if (abort && state_q != IDLE && state_q != FIN) begin
            abrt_d  = 1'b1;
            phase_d = 1'b0;
            state_d = ADV;
            cnt_d   = GAP_LD;
        end

        setb_d  = (state_d == M_RUN) || (state_d == T_RUN);
        ena_d   = (state_d == T_RUN) || (state_d == T_CAP) || ((state_d == T_ARM) && phase_d);
        sdone_d = (state_d == FIN) && (state_q != FIN);
    end

    always_ff @(posedge rclk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mask_q   <= '0;
            err_q    <= '0;
            sel_q    <= '0;
            setb_q   <= 1'b0;
            ena_q    <= 1'b0;
            busy_q   <= 1'b0;
            sdone_q  <= 1'b0;
            phase_q  <= 1'b0;
            abrt_q   <= 1'b0;
            done_p_q <= 1'b0;
            trim_q   <= '0;
            meas_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            err_q    <= err_d;
            sel_q    <= sel_d;
            setb_q   <= setb_d;
            ena_q    <= ena_d;
            busy_q   <= busy_d;
            sdone_q  <= sdone_d;
            phase_q  <= phase_d;
            abrt_q   <= abrt_d;
            done_p_q <= done_s;
            trim_q   <= trim_d;
            meas_q   <= meas_d;
        end
    end

    assign chan_sel = sel_q;
    assign ft_setb  = setb_q;
    assign ft_ena   = ena_q;
    assign ft_msb   = msb_tab[4*sel_q +: 4];
    assign busy     = busy_q;
    assign seq_done = sdone_q;
    assign err      = err_q;
    assign trim_out = trim_q;
    assign meas_out = meas_q;

endmodule

// File: tb/tb_freq_trim_seq.sv
// tb/tb_freq_trim_seq.sv - self-checking bench for freq_trim_seq with a behavioural engine
module tb_freq_trim_seq;

    localparam int NCH = 6;
    localparam int GAP = 4;
    localparam int TMO = 1000;

    logic              rstb;
    logic              rclk;
    logic              start;
    logic              abort;
    logic [NCH-1:0]    chan_mask;
    logic [4*NCH-1:0]  msb_tab;
    logic [2:0]        chan_sel;
    logic              ft_setb;
    logic              ft_ena;
    logic [3:0]        ft_msb;
    logic              ft_done;
    logic [15:0]       ft_trim;
    logic [15:0]       ft_ocnt;
    logic              busy;
    logic              seq_done;
    logic [NCH-1:0]    err;
    logic [16*NCH-1:0] trim_out;
    logic [16*NCH-1:0] meas_out;

    int checks = 0;
    int errors = 0;

    freq_trim_seq #(.NCH(NCH), .GAP(GAP), .TMO(TMO)) dut (
        .rstb      (rstb),
        .rclk      (rclk),
        .start     (start),
        .abort     (abort),
        .chan_mask (chan_mask),
        .msb_tab   (msb_tab),
        .chan_sel  (chan_sel),
        .ft_setb   (ft_setb),
        .ft_ena    (ft_ena),
        .ft_msb    (ft_msb),
        .ft_done   (ft_done),
        .ft_trim   (ft_trim),
        .ft_ocnt   (ft_ocnt),
        .busy      (busy),
        .seq_done  (seq_done),
        .err       (err),
        .trim_out  (trim_out),
        .meas_out  (meas_out)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [15:0] meas_val(input int r, input int k);
        return 16'((r << 8) | k);
    endfunction

    function automatic logic [15:0] trim_val(input int r, input int k);
        return 16'(((r ^ 'h5A) << 8) | (k << 4) | 3);
    endfunction

    logic [NCH-1:0] stall_mask = '0;
    int             run_len    = 20;
    int             run_id     = 0;
    int             eng_cnt    = 0;
    int             setb_rises = 0;
    int             msb_bad    = 0;
    int             sel_bad    = 0;
    logic           prev_setb  = 1'b0;
    logic [2:0]     prev_sel   = '0;
    int             exp_visits[$];
    logic [15:0]    meas_exp[NCH];
    logic [15:0]    trim_exp[NCH];

    // Engine model plus visit scoreboard: each measure-pass launch pops the next expected channel.
    always @(negedge rclk) begin
        if (!ft_setb) begin
            eng_cnt = 0;
            ft_done = 1'b0;
        end else if (!stall_mask[chan_sel] && !ft_done) begin
            eng_cnt++;
            if (eng_cnt >= run_len) begin
                ft_ocnt = meas_val(run_id, int'(chan_sel));
                if (ft_ena) ft_trim = trim_val(run_id, int'(chan_sel));
                ft_done = 1'b1;
            end
        end
        if (ft_setb && !prev_setb) begin
            setb_rises++;
            if (ft_msb !== msb_tab[4*chan_sel +: 4]) msb_bad++;
            if (!ft_ena) begin
                if (exp_visits.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL visit_unexpected got=%0d exp=none", chan_sel);
                end else begin
                    chk("visit_order", 128'(chan_sel), 128'(exp_visits.pop_front()));
                end
            end
        end
        if (ft_setb && prev_setb && chan_sel !== prev_sel) sel_bad++;
        prev_setb = ft_setb;
        prev_sel  = chan_sel;
    end

    typedef struct {
        logic [NCH-1:0] mask;
        logic [NCH-1:0] stall;
        logic [NCH-1:0] err;
        bit             busy_start;
        bit             abort_with_start;
    } vec_t;

    vec_t vecs[5];

    task automatic run_seq(input vec_t v, input string tag);
        int cyc;
        bit seen;
        run_id++;
        stall_mask = v.stall;
        for (int k = 0; k < NCH; k++) begin
            if (v.mask[k]) begin
                exp_visits.push_back(k);
                if (!v.stall[k]) begin
                    meas_exp[k] = meas_val(run_id, k);
                    trim_exp[k] = trim_val(run_id, k);
                end
            end
        end
        chan_mask = v.mask;
        start     = 1'b1;
        abort     = v.abort_with_start;
        @(posedge rclk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk($sformatf("%s_busy", tag), 128'(busy), 128'(1));
        seen = 0;
        for (cyc = 0; cyc < 20000 && !seen; cyc++) begin
            if (v.busy_start && cyc == 30) begin
                chan_mask = '1;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge rclk); #1;
            if (seq_done) seen = 1;
        end
        start = 1'b0;
        chk($sformatf("%s_seq_done", tag), 128'(seen), 128'(1));
        chk($sformatf("%s_err", tag), 128'(err), 128'(v.err));
        for (int k = 0; k < NCH; k++) begin
            chk($sformatf("%s_meas%0d", tag, k), 128'(meas_out[16*k +: 16]), 128'(meas_exp[k]));
            chk($sformatf("%s_trim%0d", tag, k), 128'(trim_out[16*k +: 16]), 128'(trim_exp[k]));
        end
        chk($sformatf("%s_visits_left", tag), 128'(exp_visits.size()), 128'(0));
        exp_visits.delete();
        @(posedge rclk); #1;
        chk($sformatf("%s_busy_end", tag), 128'(busy), 128'(0));
        chk($sformatf("%s_done_pulse", tag), 128'(seq_done), 128'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        int  rises0;
        bit  seen;

        vecs[0] = '{mask: 6'b000001, stall: 6'b000000, err: 6'b000000, busy_start: 0, abort_with_start: 0};
        vecs[1] = '{mask: 6'b101010, stall: 6'b000000, err: 6'b000000, busy_start: 1, abort_with_start: 0};
        vecs[2] = '{mask: 6'b000111, stall: 6'b000100, err: 6'b000100, busy_start: 0, abort_with_start: 0};
        vecs[3] = '{mask: 6'b111111, stall: 6'b100001, err: 6'b100001, busy_start: 0, abort_with_start: 1};
        vecs[4] = '{mask: 6'b011000, stall: 6'b000000, err: 6'b000000, busy_start: 0, abort_with_start: 0};

        for (int k = 0; k < NCH; k++) begin
            meas_exp[k] = '0;
            trim_exp[k] = '0;
        end
        rstb      = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        chan_mask = '0;
        msb_tab   = {4'd11, 4'd3, 4'd11, 4'd2, 4'd7, 4'd7};
        ft_done   = 1'b0;
        ft_trim   = '0;
        ft_ocnt   = '0;

        repeat (3) @(posedge rclk);
        #1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_seq_done", 128'(seq_done), 128'(0));
        chk("rst_setb", 128'(ft_setb), 128'(0));
        chk("rst_ena", 128'(ft_ena), 128'(0));
        chk("rst_chan_sel", 128'(chan_sel), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_trim", 128'(trim_out), 128'(0));
        chk("rst_meas", 128'(meas_out), 128'(0));
        rstb = 1'b1;
        repeat (2) @(posedge rclk);
        #1;

        for (int i = 0; i < 5; i++) run_seq(vecs[i], $sformatf("vec%0d", i));

        // Abort 50 cycles into the trim run of channel 0, mask 000011.
        run_len    = 200;
        run_id++;
        stall_mask = '0;
        exp_visits.push_back(0);
        meas_exp[0] = meas_val(run_id, 0);
        chan_mask = 6'b000011;
        start     = 1'b1;
        @(posedge rclk); #1;
        start = 1'b0;
        seen  = 0;
        for (cyc = 0; cyc < 5000 && !seen; cyc++) begin
            @(posedge rclk); #1;
            if (ft_setb && ft_ena) seen = 1;
        end
        chk("abort_reach_trun", 128'(seen), 128'(1));
        repeat (50) @(posedge rclk);
        #1;
        abort = 1'b1;
        @(posedge rclk); #1;
        abort = 1'b0;
        chk("abort_setb_low", 128'(ft_setb), 128'(0));
        chk("abort_ena_low", 128'(ft_ena), 128'(0));
        chk("abort_busy_held", 128'(busy), 128'(1));
        seen = 0;
        for (cyc = 0; cyc < 100 && busy; cyc++) begin
            @(posedge rclk); #1;
            if (seq_done) seen = 1;
        end
        chk("abort_busy_fall", 128'(cyc), 128'(GAP + 1));
        chk("abort_seq_done", 128'(seen), 128'(1));
        chk("abort_chan_sel", 128'(chan_sel), 128'(0));
        chk("abort_err", 128'(err), 128'(0));
        chk("abort_meas0", 128'(meas_out[15:0]), 128'(meas_exp[0]));
        chk("abort_trim0", 128'(trim_out[15:0]), 128'(trim_exp[0]));
        chk("abort_visits_left", 128'(exp_visits.size()), 128'(0));
        exp_visits.delete();

        // Empty mask: seq_done two cycles after start, setb never raised.
        rises0    = setb_rises;
        chan_mask = '0;
        start     = 1'b1;
        @(posedge rclk); #1;
        start = 1'b0;
        chk("zero_done_early", 128'(seq_done), 128'(0));
        @(posedge rclk); #1;
        chk("zero_seq_done", 128'(seq_done), 128'(1));
        @(posedge rclk); #1;
        chk("zero_busy_end", 128'(busy), 128'(0));
        chk("zero_no_setb", 128'(setb_rises), 128'(rises0));

        // Reset asserted during the measure run of channel 0.
        run_id++;
        exp_visits.push_back(0);
        chan_mask = 6'b000001;
        start     = 1'b1;
        @(posedge rclk); #1;
        start = 1'b0;
        seen  = 0;
        for (cyc = 0; cyc < 1000 && !seen; cyc++) begin
            @(posedge rclk); #1;
            if (ft_setb) seen = 1;
        end
        chk("rst2_reach_mrun", 128'(seen), 128'(1));
        repeat (5) @(posedge rclk);
        #1;
        rstb = 1'b0;
        #1;
        chk("rst2_busy", 128'(busy), 128'(0));
        chk("rst2_setb", 128'(ft_setb), 128'(0));
        chk("rst2_chan_sel", 128'(chan_sel), 128'(0));
        chk("rst2_err", 128'(err), 128'(0));
        chk("rst2_meas", 128'(meas_out), 128'(0));
        chk("rst2_trim", 128'(trim_out), 128'(0));
        exp_visits.delete();
        for (int k = 0; k < NCH; k++) begin
            meas_exp[k] = '0;
            trim_exp[k] = '0;
        end
        repeat (2) @(posedge rclk);
        #1;
        rstb    = 1'b1;
        run_len = 20;
        @(posedge rclk); #1;
        run_seq('{mask: 6'b000101, stall: 6'b000000, err: 6'b000000, busy_start: 0, abort_with_start: 0}, "post_rst");

        chk("setb_sel_stable", 128'(sel_bad), 128'(0));
        chk("msb_route", 128'(msb_bad), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
